// File: rtl/rf_pkg.sv
// Register-file constants and types shared by the register file, the decode stage
// and the read-side scoreboard.
package rf_pkg;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // x0 is hardwired to zero, so it never carries a pending write.
    function automatic logic is_tracked(input reg_addr_t addr);
        return addr != REG_ZERO;
    endfunction
endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter for the scoreboard: counts issued writes up and
// completed writebacks down; simultaneous inc and dec leave the count unchanged.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             at_max
);
    logic [CNT_W-1:0] count_reg;

    // Overflow/underflow are prevented upstream (saturation stall, dec only when nonzero).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= '0;
        end else if (inc && !dec) begin
            count_reg <= count_reg + 1'b1;
        end else if (dec && !inc) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count   = count_reg;
    assign nonzero = (count_reg != '0);
    assign at_max  = (count_reg == '1);
endmodule

// File: rtl/rf_scoreboard.sv
// Read-side RAW/WAW hazard scoreboard for the 32x32 register file with a global
// in-flight write cap. Define SB_WB_BYPASS_EN to let same-cycle writebacks release hazards.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_issue_valid,
    output logic                o_issue_ready,
    input  logic [4:0]          i_issue_rs1,
    input  logic                i_issue_rs1_used,
    input  logic [4:0]          i_issue_rs2,
    input  logic                i_issue_rs2_used,
    input  logic                i_issue_rd_wen,
    input  logic [4:0]          i_issue_rd,
    input  logic                i_wb_valid,
    input  logic [4:0]          i_wb_rd,
    output logic [NUM_REGS-1:0] o_busy,
    output logic [5:0]          o_inflight,
    output logic                o_err
);
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            nonzero_vec;
    logic [NUM_REGS-1:0]            at_max_vec;
    logic [NUM_REGS-1:0]            inc_vec;
    logic [NUM_REGS-1:0]            dec_vec;

    logic [5:0] inflight_reg;
    logic [5:0] inflight_next;
    logic       err_reg;

    logic fire;
    logic issue_counts;
    logic wb_release;
    logic wb_error;
    logic raw1;
    logic raw2;
    logic sat;
    logic full;
    logic rel_rs1;
    logic rel_rs2;
    logic rel_rd;
    logic rel_any;

    assign issue_counts = i_issue_rd_wen && is_tracked(i_issue_rd);
    assign fire         = i_issue_valid && o_issue_ready;

    // A writeback only releases something if the register actually has a pending write.
    assign wb_release = i_wb_valid && is_tracked(i_wb_rd) && nonzero_vec[i_wb_rd];
    assign wb_error   = i_wb_valid && is_tracked(i_wb_rd) && !nonzero_vec[i_wb_rd];

`ifdef SB_WB_BYPASS_EN
    assign rel_rs1 = wb_release && (i_wb_rd == i_issue_rs1);
    assign rel_rs2 = wb_release && (i_wb_rd == i_issue_rs2);
    assign rel_rd  = wb_release && (i_wb_rd == i_issue_rd);
    assign rel_any = wb_release;
`else
    assign rel_rs1 = 1'b0;
    assign rel_rs2 = 1'b0;
    assign rel_rd  = 1'b0;
    assign rel_any = 1'b0;
`endif

    // pend(rs) = cnt[rs] - same-cycle release; release implies cnt != 0, so no underflow.
    assign raw1 = i_issue_rs1_used && is_tracked(i_issue_rs1)
                  && ((cnt[i_issue_rs1] - CNT_W'(rel_rs1)) != '0);
    assign raw2 = i_issue_rs2_used && is_tracked(i_issue_rs2)
                  && ((cnt[i_issue_rs2] - CNT_W'(rel_rs2)) != '0);
    assign sat  = issue_counts && at_max_vec[i_issue_rd] && !rel_rd;
    assign full = issue_counts && (inflight_reg == 6'(MAX_INFLIGHT)) && !rel_any;

    assign o_issue_ready = !(raw1 || raw2 || sat || full);

    assign cnt[0]         = '0;
    assign nonzero_vec[0] = 1'b0;
    assign at_max_vec[0]  = 1'b0;
    assign inc_vec[0]     = 1'b0;
    assign dec_vec[0]     = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            assign inc_vec[gi] = fire && issue_counts && (i_issue_rd == 5'(gi));
            assign dec_vec[gi] = wb_release && (i_wb_rd == 5'(gi));

            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .inc     (inc_vec[gi]),
                .dec     (dec_vec[gi]),
                .count   (cnt[gi]),
                .nonzero (nonzero_vec[gi]),
                .at_max  (at_max_vec[gi])
            );
        end
    endgenerate

    assign inflight_next = inflight_reg + 6'(fire && issue_counts) - 6'(wb_release);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            inflight_reg <= inflight_next;
            if (wb_error) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Busy bits are a pure function of the counter flops, so they change only at the edge.
    assign o_busy     = nonzero_vec;
    assign o_inflight = inflight_reg;
    assign o_err      = err_reg;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Randomised plus directed bench for rf_scoreboard against an array-based model of the
// pending-write rules; honours SB_WB_BYPASS_EN the same way as the design.
module tb_rf_scoreboard;
    localparam int CNT_W        = 2;
    localparam int MAX_INFLIGHT = 8;
    localparam int CMAX         = (1 << CNT_W) - 1;
`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_ready;
    logic [4:0]  rs1, rs2, rd, wb_rd;
    logic        rs1_used, rs2_used, rd_wen, wb_valid;
    logic [31:0] busy;
    logic [5:0]  inflight;
    logic        err;

    int errors = 0;
    int checks = 0;

    // behavioural model
    int m_cnt [32];
    int m_inflight;
    bit m_err;
    bit ready_s;

    always #5 clk = ~clk;

    rf_scoreboard #(.CNT_W(CNT_W), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_issue_valid(issue_valid), .o_issue_ready(issue_ready),
        .i_issue_rs1(rs1), .i_issue_rs1_used(rs1_used),
        .i_issue_rs2(rs2), .i_issue_rs2_used(rs2_used),
        .i_issue_rd_wen(rd_wen), .i_issue_rd(rd),
        .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
        .o_busy(busy), .o_inflight(inflight), .o_err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_inflight = 0;
        m_err      = 1'b0;
    endtask

    function automatic bit released(input int r);
        return wb_valid && wb_rd != 0 && int'(wb_rd) == r && m_cnt[r] > 0;
    endfunction

    function automatic int pend(input int r);
        return m_cnt[r] - ((BYP && released(r)) ? 1 : 0);
    endfunction

    function automatic bit model_ready();
        bit any_rel, raw1, raw2, sat, full;
        any_rel = wb_valid && wb_rd != 0 && m_cnt[wb_rd] > 0;
        raw1 = rs1_used && rs1 != 0 && pend(int'(rs1)) != 0;
        raw2 = rs2_used && rs2 != 0 && pend(int'(rs2)) != 0;
        sat  = rd_wen && rd != 0 && (m_cnt[rd] - ((BYP && released(int'(rd))) ? 1 : 0)) == CMAX;
        full = rd_wen && rd != 0 && (m_inflight - ((BYP && any_rel) ? 1 : 0)) == MAX_INFLIGHT;
        return !(raw1 || raw2 || sat || full);
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    task automatic setin(input bit v, input int a1, input bit u1, input int a2, input bit u2,
                         input bit w, input int d, input bit wv, input int wd);
        issue_valid = v;  rs1 = 5'(a1); rs1_used = u1; rs2 = 5'(a2); rs2_used = u2;
        rd_wen = w; rd = 5'(d); wb_valid = wv; wb_rd = 5'(wd);
    endtask

    task automatic idle_in();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare everything against the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        bit exp_ready, f;
        int inc_r, dec_r;
        #1;
        exp_ready = model_ready();
        chk("ready", 32'(issue_ready), 32'(exp_ready));
        chk("busy", busy, model_busy());
        chk("inflight", 32'(inflight), 32'(m_inflight));
        chk("err", 32'(err), 32'(m_err));
        ready_s = issue_ready;
        f = issue_valid && exp_ready;
        inc_r = (f && rd_wen && rd != 0) ? int'(rd) : 0;
        dec_r = (wb_valid && wb_rd != 0 && m_cnt[wb_rd] > 0) ? int'(wb_rd) : 0;
        if (wb_valid && wb_rd != 0 && m_cnt[wb_rd] == 0) m_err = 1'b1;
        @(posedge clk);
        if (inc_r != 0) begin m_cnt[inc_r]++; m_inflight++; end
        if (dec_r != 0) begin m_cnt[dec_r]--; m_inflight--; end
        @(negedge clk);
        $display("cyc v=%0b rd=%0d rs1=%0d rs2=%0d wb=%0b/%0d ready=%0b busy=%08h infl=%0d err=%0b",
                 issue_valid, rd, rs1, rs2, wb_valid, wb_rd, ready_s, busy, inflight, err);
    endtask

    task automatic drain();
        for (int r = 1; r < 32; r++) begin
            while (m_cnt[r] > 0) begin
                setin(0, 0, 0, 0, 0, 0, 0, 1, r);
                tick();
            end
        end
        idle_in();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_busy", busy, 32'h0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);

        // RAW on x5, released by writeback
        setin(1, 0, 0, 0, 0, 1, 5, 0, 0);  tick(); chk("raw_issue_ready", 32'(ready_s), 1);
        chk("raw_busy", busy, 32'h20);
        chk("raw_inflight", 32'(inflight), 1);
        setin(1, 5, 1, 0, 0, 0, 0, 0, 0);  tick(); chk("raw_stall", 32'(ready_s), 0);
        setin(1, 5, 1, 0, 0, 0, 0, 1, 5);  tick(); chk("raw_wb_cycle", 32'(ready_s), 32'(BYP));
        chk("raw_released", busy, 32'h0);
        setin(1, 5, 1, 0, 0, 0, 0, 0, 0);  tick(); chk("raw_after_wb", 32'(ready_s), 1);

        // x0 is never tracked
        for (int i = 0; i < 3; i++) begin
            setin(1, 0, 1, 0, 1, 1, 0, 0, 0); tick(); chk("x0_ready", 32'(ready_s), 1);
        end
        chk("x0_busy", busy, 0);
        chk("x0_inflight", 32'(inflight), 0);
        setin(0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); chk("x0_wb_err", 32'(err), 0);

        // WAW saturation on x7
        setin(1, 0, 0, 0, 0, 1, 7, 0, 0); tick(); chk("waw_busy7", 32'(busy[7]), 1);
        tick(); tick();
        chk("waw_inflight3", 32'(inflight), 3);
        tick(); chk("waw_sat", 32'(ready_s), 0);
        setin(0, 0, 0, 0, 0, 0, 0, 1, 7); tick(); chk("waw_cnt2", 32'(inflight), 2);
        setin(1, 0, 0, 0, 0, 1, 7, 0, 0); tick(); chk("waw_unsat", 32'(ready_s), 1);
        drain();

        // Capacity cap
        for (int r = 1; r <= 8; r++) begin
            setin(1, 0, 0, 0, 0, 1, r, 0, 0); tick();
        end
        chk("cap_inflight8", 32'(inflight), 8);
        setin(1, 0, 0, 0, 0, 1, 9, 0, 0); tick(); chk("cap_full", 32'(ready_s), 0);
        setin(1, 0, 0, 0, 0, 1, 9, 1, 1); tick(); chk("cap_full_wb", 32'(ready_s), 32'(BYP));
        chk("cap_inflight_after", 32'(inflight), BYP ? 8 : 7);
        drain();

        // Simultaneous issue and writeback to the same register
        setin(1, 0, 0, 0, 0, 1, 3, 0, 0); tick();
        setin(1, 0, 0, 0, 0, 1, 3, 1, 3); tick(); chk("same_ready", 32'(ready_s), 1);
        chk("same_busy3", 32'(busy[3]), 1);
        chk("same_inflight", 32'(inflight), 1);
        drain();

        // Random traffic; writebacks only target pending registers here
        for (int n = 0; n < 3000; n++) begin
            int wd;
            bit wv;
            wd = $urandom_range(0, 9);
            wv = ($urandom_range(0, 1) == 1) && (wd == 0 || m_cnt[wd] > 0);
            setin($urandom_range(0, 3) != 0, $urandom_range(0, 9), $urandom_range(0, 1),
                  $urandom_range(0, 9), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9), wv, wd);
            tick();
        end
        drain();

        // Sticky error
        setin(0, 0, 0, 0, 0, 0, 0, 1, 12); tick(); chk("err_set", 32'(err), 1);
        for (int n = 0; n < 20; n++) begin
            setin(1, $urandom_range(0, 9), 1, 0, 0, 1, $urandom_range(1, 9), 0, 0);
            tick();
        end
        chk("err_sticky", 32'(err), 1);

        // Asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_inflight", 32'(inflight), 0);
        chk("arst_err", 32'(err), 0);
        model_reset();
        idle_in();
        @(negedge clk);
        rst_n = 1'b1;
        setin(1, 0, 0, 0, 0, 1, 4, 0, 0); tick();
        chk("post_rst_busy", busy, 32'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
